// File: rtl/bmc_soft_pipe.sv
// Soft-decision branch-metric calculator for a rate 1/N_CODE Viterbi decoder.
// Two-stage pipeline: masked per-bit distances, then per-hypothesis sums, with ready/valid flow control.
module bmc_soft_pipe #(
    parameter int N_CODE = 2,
    parameter int Q_BITS = 3,
    parameter int PUNC_LEN = 1,
    parameter logic [N_CODE*PUNC_LEN-1:0] PUNC_PATTERN = '1,
    localparam int SMAX = (1 << Q_BITS) - 1,
    localparam int BM_W = $clog2(N_CODE * SMAX + 1),
    localparam int N_HYP = 1 << N_CODE,
    localparam int PH_W = (PUNC_LEN > 1) ? $clog2(PUNC_LEN) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_CODE*Q_BITS-1:0] rx_sym,
    input  logic [N_CODE-1:0]        erase,
    input  logic                     punc_en,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_HYP*BM_W-1:0]    bm,
    output logic [PH_W-1:0]          out_phase
);

    logic                           adv;
    logic                           accept;
    logic [PH_W-1:0]                phase_cnt;
    logic [PH_W-1:0]                phase_cur;
    logic [N_CODE-1:0]              keep;
    logic [N_CODE-1:0][Q_BITS-1:0]  d0_nxt;
    logic [N_CODE-1:0][Q_BITS-1:0]  d1_nxt;
    logic [N_HYP-1:0][BM_W-1:0]     bm_nxt;

    logic [N_CODE-1:0][Q_BITS-1:0]  d0_p1;
    logic [N_CODE-1:0][Q_BITS-1:0]  d1_p1;
    logic [PH_W-1:0]                phase_p1;
    logic                           vld_p1;

    logic [N_HYP-1:0][BM_W-1:0]     bm_p2;
    logic [PH_W-1:0]                phase_p2;
    logic                           vld_p2;

    // Distance of one soft sample from a hypothesised code bit (0 = strongest "0").
    function automatic logic [Q_BITS-1:0] bit_dist(input logic [Q_BITS-1:0] s, input logic hyp);
        return hyp ? (Q_BITS'(SMAX) - s) : s;
    endfunction

    function automatic logic [N_CODE-1:0] keep_mask(input logic pen, input logic [PH_W-1:0] ph);
        if (!pen)
            return '1;
        return PUNC_PATTERN[int'(ph)*N_CODE +: N_CODE];
    endfunction

    // Width is sized so the worst case N_CODE*SMAX fits; no saturation needed.
    function automatic logic [BM_W-1:0] sum_dist(
        input logic [N_CODE-1:0][Q_BITS-1:0] d0,
        input logic [N_CODE-1:0][Q_BITS-1:0] d1,
        input logic [N_CODE-1:0]             hyp
    );
        logic [BM_W-1:0] acc;
        acc = '0;
        for (int j = 0; j < N_CODE; j++)
            acc = acc + BM_W'(hyp[j] ? d1[j] : d0[j]);
        return acc;
    endfunction

    assign adv       = out_ready | ~vld_p2;
    assign in_ready  = adv;
    assign accept    = in_valid & adv & ~flush;
    assign phase_cur = punc_en ? phase_cnt : '0;

    always_comb begin
        keep   = keep_mask(punc_en, phase_cur);
        d0_nxt = '0;
        d1_nxt = '0;
        for (int j = 0; j < N_CODE; j++) begin
            if (keep[j] && !erase[j]) begin
                d0_nxt[j] = bit_dist(rx_sym[j*Q_BITS +: Q_BITS], 1'b0);
                d1_nxt[j] = bit_dist(rx_sym[j*Q_BITS +: Q_BITS], 1'b1);
            end
        end
    end

    always_comb begin
        bm_nxt = '0;
        for (int k = 0; k < N_HYP; k++)
            bm_nxt[k] = sum_dist(d0_p1, d1_p1, N_CODE'(k));
    end

    // Control: valids, phases and puncture counter; flush beats advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            phase_p1  <= '0;
            phase_p2  <= '0;
            phase_cnt <= '0;
        end else if (flush) begin
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            phase_cnt <= '0;
        end else begin
            if (adv) begin
                vld_p1   <= in_valid;
                vld_p2   <= vld_p1;
                phase_p1 <= phase_cur;
                phase_p2 <= phase_p1;
            end
            if (!punc_en)
                phase_cnt <= '0;
            else if (accept)
                phase_cnt <= (phase_cnt == PH_W'(PUNC_LEN - 1)) ? '0 : phase_cnt + 1'b1;
        end
    end

    // Stage 1 -> stage 2 datapath; loads on every advance so idle slots stay deterministic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d0_p1 <= '0;
            d1_p1 <= '0;
            bm_p2 <= '0;
        end else if (adv) begin
            d0_p1 <= d0_nxt;
            d1_p1 <= d1_nxt;
            bm_p2 <= bm_nxt;
        end
    end

    assign out_valid = vld_p2;
    assign bm        = bm_p2;
    assign out_phase = phase_p2;

endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Scoreboard bench for bmc_soft_pipe: a punctured soft-decision instance and a hard-decision instance.
module tb_bmc_soft_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, punc_en, flush, out_valid, out_ready;
    logic [5:0]  rx_sym;
    logic [1:0]  erase;
    logic [15:0] bm;
    logic [0:0]  out_phase;

    logic        hd_valid, hd_ready, hd_out_valid;
    logic [1:0]  hd_sym;
    logic [7:0]  hd_bm;
    logic [0:0]  hd_phase;

    typedef struct {
        logic [15:0] bm;
        logic        ph;
        int          acc;
        logic        lat;
    } ent_t;

    ent_t        sb[$];
    logic [7:0]  hd_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    string       tag = "reset";

    bmc_soft_pipe #(.N_CODE(2), .Q_BITS(3), .PUNC_LEN(2), .PUNC_PATTERN(4'b0111)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .rx_sym(rx_sym),
        .erase(erase), .punc_en(punc_en), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .bm(bm), .out_phase(out_phase)
    );

    bmc_soft_pipe #(.N_CODE(2), .Q_BITS(1)) u_hd (
        .clk(clk), .rst(rst), .in_valid(hd_valid), .in_ready(hd_ready), .rx_sym(hd_sym),
        .erase(2'b00), .punc_en(1'b0), .flush(1'b0), .out_valid(hd_out_valid),
        .out_ready(1'b1), .bm(hd_bm), .out_phase(hd_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s [%s] got=%0h expected=%0h at t=%0t", nm, tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pk4(input int a, input int b, input int c, input int d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    function automatic logic [7:0] pk2(input int a, input int b, input int c, input int d);
        return {2'(d), 2'(c), 2'(b), 2'(a)};
    endfunction

    // Present one symbol, wait (bounded) for acceptance, then log the hand-computed expectation.
    task automatic send(input int b1, input int b0, input logic [1:0] er, input logic pe,
                        input logic [15:0] ebm, input logic eph, input logic lat);
        ent_t e;
        logic ok;
        int   n;
        rx_sym   = {3'(b1), 3'(b0)};
        erase    = er;
        punc_en  = pe;
        in_valid = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        chk("send_accept", 32'(ok), 32'd1);
        e.bm  = ebm;
        e.ph  = eph;
        e.acc = cyc;
        e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", 32'(out_valid), 32'd0);
            end else if (out_ready) begin
                ent_t e;
                e = sb.pop_front();
                chk("bm", 32'(bm), 32'(e.bm));
                chk("out_phase", 32'(out_phase), 32'(e.ph));
                if (e.lat)
                    chk("latency", 32'(cyc - e.acc + 1), 32'd2);
            end else begin
                chk("hold_bm", 32'(bm), 32'(sb[0].bm));
                chk("hold_phase", 32'(out_phase), 32'(sb[0].ph));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && hd_out_valid) begin
            if (hd_q.size() == 0)
                chk("hd_spurious", 32'(hd_out_valid), 32'd0);
            else
                chk("hd_bm", 32'(hd_bm), 32'(hd_q.pop_front()));
        end
    end

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; rx_sym = '0; erase = '0; punc_en = 1'b0;
        flush = 1'b0; out_ready = 1'b1; hd_valid = 1'b0; hd_sym = '0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_bm", 32'(bm), 32'd0);
        chk("rst_out_phase", 32'(out_phase), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        #19 rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        tag = "hard_decision";
        hd_valid = 1'b1;
        hd_sym = 2'b01; hd_q.push_back(pk2(1, 0, 2, 1)); @(posedge clk); #1;
        hd_sym = 2'b10; hd_q.push_back(pk2(1, 2, 0, 1)); @(posedge clk); #1;
        hd_sym = 2'b11; hd_q.push_back(pk2(2, 1, 1, 0)); @(posedge clk); #1;
        hd_sym = 2'b00; hd_q.push_back(pk2(0, 1, 1, 2)); @(posedge clk); #1;
        hd_valid = 1'b0;
        idle(4);

        tag = "soft_erase";
        send(7, 0, 2'b00, 1'b0, pk4(7, 14, 0, 7), 1'b0, 1'b1);
        idle(1);
        send(5, 2, 2'b11, 1'b0, pk4(0, 0, 0, 0), 1'b0, 1'b1);
        send(7, 3, 2'b01, 1'b0, pk4(7, 7, 0, 0), 1'b0, 1'b1);
        send(3, 5, 2'b00, 1'b0, pk4(8, 5, 9, 6), 1'b0, 1'b1);
        send(0, 0, 2'b00, 1'b0, pk4(0, 7, 7, 14), 1'b0, 1'b1);
        send(6, 1, 2'b10, 1'b0, pk4(1, 6, 1, 6), 1'b0, 1'b1);
        idle(4);

        tag = "puncture";
        send(7, 7, 2'b00, 1'b1, pk4(14, 7, 7, 0), 1'b0, 1'b1);
        send(7, 7, 2'b00, 1'b1, pk4(7, 0, 7, 0), 1'b1, 1'b1);
        send(2, 5, 2'b00, 1'b1, pk4(7, 4, 10, 7), 1'b0, 1'b1);
        send(2, 5, 2'b00, 1'b1, pk4(5, 2, 5, 2), 1'b1, 1'b1);
        send(7, 7, 2'b00, 1'b1, pk4(14, 7, 7, 0), 1'b0, 1'b1);
        send(7, 7, 2'b00, 1'b0, pk4(14, 7, 7, 0), 1'b0, 1'b1);
        send(7, 7, 2'b00, 1'b1, pk4(14, 7, 7, 0), 1'b0, 1'b1);
        idle(4);

        tag = "backpressure";
        out_ready = 1'b0;
        fork
            begin
                send(7, 0, 2'b00, 1'b0, pk4(7, 14, 0, 7), 1'b0, 1'b0);
                send(3, 5, 2'b00, 1'b0, pk4(8, 5, 9, 6), 1'b0, 1'b0);
                send(0, 0, 2'b00, 1'b0, pk4(0, 7, 7, 14), 1'b0, 1'b0);
                send(6, 1, 2'b10, 1'b0, pk4(1, 6, 1, 6), 1'b0, 1'b0);
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(negedge clk);
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                chk("stall_out_valid", 32'(out_valid), 32'd1);
                @(posedge clk); #2;
                out_ready = 1'b1;
            end
        join
        idle(6);

        tag = "flush";
        send(7, 7, 2'b00, 1'b1, pk4(14, 7, 7, 0), 1'b0, 1'b1);
        idle(3);
        out_ready = 1'b0;
        send(7, 7, 2'b00, 1'b1, pk4(7, 0, 7, 0), 1'b1, 1'b0);
        send(2, 5, 2'b00, 1'b1, pk4(7, 4, 10, 7), 1'b0, 1'b0);
        rx_sym = {3'd3, 3'd3}; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(7, 7, 2'b00, 1'b1, pk4(14, 7, 7, 0), 1'b0, 1'b1);
        idle(4);

        tag = "async_reset";
        out_ready = 1'b0;
        send(7, 7, 2'b00, 1'b1, pk4(7, 0, 7, 0), 1'b1, 1'b0);
        send(2, 5, 2'b00, 1'b1, pk4(7, 4, 10, 7), 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_bm", 32'(bm), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        #3 rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(7, 7, 2'b00, 1'b1, pk4(14, 7, 7, 0), 1'b0, 1'b1);
        idle(2);

        tag = "drain";
        n = 0;
        while ((sb.size() != 0 || hd_q.size() != 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("hd_q_empty", 32'(hd_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
